// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the error-response FSM state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ERR_IDLE = 2'd0,
    ERR_1    = 2'd1,
    ERR_2    = 2'd2
  } err_state_e;

endpackage

// File: rtl/ahb_err_fsm.sv
// Two-cycle AHB ERROR response sequencer: ERR1 stalls with ERROR, ERR2 completes it.
module ahb_err_fsm
  import ahb_pkg::*;
(
  input  logic hclk,
  input  logic hreset_n,
  input  logic start,
  output logic hready_out,
  output logic hresp
);

  err_state_e state, state_nxt;

  always_ff @(posedge hclk) begin
    if (!hreset_n) state <= ERR_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    hready_out = 1'b1;
    hresp      = HRESP_OKAY;
    case (state)
      ERR_IDLE: if (start) state_nxt = ERR_1;
      ERR_1: begin
        hready_out = 1'b0;
        hresp      = HRESP_ERROR;
        state_nxt  = ERR_2;
      end
      ERR_2: begin
        hresp     = HRESP_ERROR;
        // a new illegal transfer may be accepted as ERR2 completes
        state_nxt = start ? ERR_1 : ERR_IDLE;
      end
      default: state_nxt = ERR_IDLE;
    endcase
  end

endmodule

// File: rtl/ahb_lite_reg_slave.sv
// AHB-Lite 8-bit register slave: payload (16b), data_size (5b), read-only err_status.
module ahb_lite_reg_slave
  import ahb_pkg::*;
#(
  parameter logic [2:0] ERR_STATUS_ADDRESS = 3'd1,
  parameter logic [2:0] PAYLOAD_ADDRESS    = 3'd2,
  parameter logic [2:0] DATA_SIZE_ADDRESS  = 3'd4
) (
  input  logic        hclk,
  input  logic        hreset_n,
  input  logic        hsel_x,
  input  logic        hready,
  input  logic        hwrite,
  input  logic [2:0]  haddr,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [7:0]  hwdata,
  input  logic [1:0]  err_status,
  output logic [15:0] payload,
  output logic [4:0]  data_size,
  output logic [7:0]  hrdata,
  output logic        hready_out,
  output logic        hresp
);

  localparam logic [2:0] PAYLOAD_HI_ADDRESS = PAYLOAD_ADDRESS + 3'd1;

  logic       acc, illegal, addr_ok;
  logic       dp_vld, dp_write;
  logic [2:0] dp_addr;

  always_comb begin
    acc = hsel_x && hready &&
          (htrans_e'(htrans) == HTRANS_NONSEQ || htrans_e'(htrans) == HTRANS_SEQ);
    addr_ok = (haddr == ERR_STATUS_ADDRESS) || (haddr == PAYLOAD_ADDRESS) ||
              (haddr == PAYLOAD_HI_ADDRESS) || (haddr == DATA_SIZE_ADDRESS);
    illegal = (hsize > HSIZE_HALF) ||
              (hsize == HSIZE_HALF && haddr[0]) ||
              !addr_ok ||
              (hwrite && haddr == ERR_STATUS_ADDRESS);
  end

  // Only legal transfers get a data phase here; illegal ones are owned by the error FSM.
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      dp_vld   <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
    end else begin
      dp_vld <= acc && !illegal;
      if (acc) begin
        dp_write <= hwrite;
        dp_addr  <= haddr;
      end
    end
  end

  // Halfword writes land in the addressed byte only: the bus carries 8 bits.
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      payload   <= '0;
      data_size <= '0;
    end else if (dp_vld && dp_write) begin
      if (dp_addr == PAYLOAD_ADDRESS)         payload[7:0]  <= hwdata;
      else if (dp_addr == PAYLOAD_HI_ADDRESS) payload[15:8] <= hwdata;
      else if (dp_addr == DATA_SIZE_ADDRESS)  data_size     <= hwdata[4:0];
    end
  end

  always_comb begin
    hrdata = '0;
    if (dp_vld && !dp_write) begin
      if (dp_addr == ERR_STATUS_ADDRESS)      hrdata = {6'b0, err_status};
      else if (dp_addr == PAYLOAD_ADDRESS)    hrdata = payload[7:0];
      else if (dp_addr == PAYLOAD_HI_ADDRESS) hrdata = payload[15:8];
      else if (dp_addr == DATA_SIZE_ADDRESS)  hrdata = {3'b0, data_size};
    end
  end

  ahb_err_fsm u_err_fsm (
    .hclk       (hclk),
    .hreset_n   (hreset_n),
    .start      (acc && illegal),
    .hready_out (hready_out),
    .hresp      (hresp)
  );

endmodule

// File: tb/tb_ahb_lite_reg_slave.sv
// Directed bench for ahb_lite_reg_slave: register writes/reads, pipelining, error responses, reset abort.
module tb_ahb_lite_reg_slave;

  logic        hclk = 1'b0;
  logic        hreset_n, hsel_x, hready, hwrite;
  logic [2:0]  haddr, hsize;
  logic [1:0]  htrans, err_status;
  logic [7:0]  hwdata;
  logic [15:0] payload;
  logic [4:0]  data_size;
  logic [7:0]  hrdata;
  logic        hready_out, hresp;

  int total = 0;
  int bad   = 0;

  ahb_lite_reg_slave dut (
    .hclk       (hclk),
    .hreset_n   (hreset_n),
    .hsel_x     (hsel_x),
    .hready     (hready),
    .hwrite     (hwrite),
    .haddr      (haddr),
    .htrans     (htrans),
    .hsize      (hsize),
    .hwdata     (hwdata),
    .err_status (err_status),
    .payload    (payload),
    .data_size  (data_size),
    .hrdata     (hrdata),
    .hready_out (hready_out),
    .hresp      (hresp)
  );

  always #5 hclk = ~hclk;

  // advance one edge, then settle so sampling is away from the edge
  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic addr_ph(input logic wr, input logic [2:0] a, input logic [2:0] sz);
    hsel_x = 1'b1; hready = 1'b1; htrans = 2'd2; hwrite = wr; haddr = a; hsize = sz;
  endtask

  task automatic idle_ph();
    hsel_x = 1'b0; htrans = 2'd0; hwrite = 1'b0; haddr = 3'd0; hsize = 3'd0;
  endtask

  logic [2:0] ill_addr [3] = '{3'd0, 3'd3, 3'd4};
  logic [2:0] ill_size [3] = '{3'd0, 3'd1, 3'd2};
  logic       ill_wr   [3] = '{1'b0, 1'b1, 1'b1};

  initial begin
    hreset_n = 1'b0; hready = 1'b1; hwdata = 8'h00; err_status = 2'b00;
    idle_ph();
    step(); step();
    chk("rst_payload", payload, 16'h0000);
    chk("rst_data_size", {11'd0, data_size}, 16'd0);
    chk("rst_hrdata", {8'd0, hrdata}, 16'd0);
    chk("rst_hready_out", {15'd0, hready_out}, 16'd1);
    chk("rst_hresp", {15'd0, hresp}, 16'd0);
    hreset_n = 1'b1;

    // write data_size = 12
    addr_ph(1'b1, 3'd4, 3'd0); step();
    idle_ph(); hwdata = 8'd12;
    chk("ds_wr_ready", {15'd0, hready_out}, 16'd1);
    chk("ds_wr_resp", {15'd0, hresp}, 16'd0);
    chk("ds_wr_hrdata", {8'd0, hrdata}, 16'd0);
    step();
    chk("ds_value", {11'd0, data_size}, 16'd12);

    // halfword write at payload low byte
    addr_ph(1'b1, 3'd2, 3'd1); step();
    idle_ph(); hwdata = 8'h29;
    chk("pl_wr_resp", {15'd0, hresp}, 16'd0);
    step();
    chk("pl_lo", payload, 16'h0029);

    // back-to-back: W3, R3, R4
    addr_ph(1'b1, 3'd3, 3'd0); step();
    hwdata = 8'h0D; addr_ph(1'b0, 3'd3, 3'd0); step();
    chk("pl_hi", payload, 16'h0D29);
    chk("rd_after_wr", {8'd0, hrdata}, 16'h000D);
    hwdata = 8'hFF; addr_ph(1'b0, 3'd4, 3'd0); step();
    chk("rd_ds_pipe", {8'd0, hrdata}, 16'd12);
    chk("rd_ds_ready", {15'd0, hready_out}, 16'd1);
    idle_ph(); step();
    chk("hrdata_idle", {8'd0, hrdata}, 16'd0);

    // read err_status
    err_status = 2'b10;
    addr_ph(1'b0, 3'd1, 3'd0); step();
    idle_ph();
    chk("rd_err_status", {8'd0, hrdata}, 16'h0002);
    chk("rd_err_resp", {15'd0, hresp}, 16'd0);
    step();

    // write to read-only err_status -> two-cycle ERROR
    addr_ph(1'b1, 3'd1, 3'd0); step();
    idle_ph(); hready = 1'b0; hwdata = 8'hFF;
    chk("ro_err1_ready", {15'd0, hready_out}, 16'd0);
    chk("ro_err1_resp", {15'd0, hresp}, 16'd1);
    step();
    hready = 1'b1;
    chk("ro_err2_ready", {15'd0, hready_out}, 16'd1);
    chk("ro_err2_resp", {15'd0, hresp}, 16'd1);
    step();
    chk("ro_idle_resp", {15'd0, hresp}, 16'd0);
    addr_ph(1'b0, 3'd1, 3'd0); step();
    idle_ph();
    chk("ro_unchanged", {8'd0, hrdata}, 16'h0002);
    step();

    // illegal: addr 0 read, addr 3 halfword write, addr 4 size 2 write
    for (int i = 0; i < 3; i++) begin
      addr_ph(ill_wr[i], ill_addr[i], ill_size[i]); step();
      idle_ph(); hready = 1'b0; hwdata = 8'hFF;
      chk($sformatf("ill%0d_err1", i), {14'd0, hready_out, hresp}, 16'b01);
      chk($sformatf("ill%0d_hrdata", i), {8'd0, hrdata}, 16'd0);
      step();
      hready = 1'b1;
      chk($sformatf("ill%0d_err2", i), {14'd0, hready_out, hresp}, 16'b11);
      step();
      chk($sformatf("ill%0d_done", i), {14'd0, hready_out, hresp}, 16'b10);
      chk($sformatf("ill%0d_payload", i), payload, 16'h0D29);
      chk($sformatf("ill%0d_ds", i), {11'd0, data_size}, 16'd12);
    end

    // IDLE with hsel_x=1 accepts nothing
    addr_ph(1'b1, 3'd4, 3'd0); htrans = 2'd0; step();
    idle_ph(); hwdata = 8'd31;
    chk("idle_resp", {14'd0, hready_out, hresp}, 16'b10);
    step();
    chk("idle_no_wr", {11'd0, data_size}, 16'd12);

    // hready=0 with NONSEQ accepts nothing
    addr_ph(1'b1, 3'd4, 3'd0); hready = 1'b0; step();
    idle_ph(); hready = 1'b1; hwdata = 8'd31;
    chk("nordy_resp", {14'd0, hready_out, hresp}, 16'b10);
    step();
    chk("nordy_no_wr", {11'd0, data_size}, 16'd12);

    // reset during a pending write data phase drops the write
    addr_ph(1'b1, 3'd4, 3'd0); step();
    idle_ph(); hwdata = 8'd7; hreset_n = 1'b0; step();
    chk("rst_mid_ds", {11'd0, data_size}, 16'd0);
    chk("rst_mid_payload", payload, 16'h0000);
    chk("rst_mid_hrdata", {8'd0, hrdata}, 16'd0);
    chk("rst_mid_resp", {14'd0, hready_out, hresp}, 16'b10);
    hreset_n = 1'b1; step();
    chk("rst_mid_after", {11'd0, data_size}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_lite_reg_slave.md
Name: ahb_lite_reg_slave

Overview:
- AHB-Lite slave with an 8-bit data bus that exposes a small register file to a bus master.
- Registers:
  - data_size: 5-bit, read/write.
  - payload: 16-bit, read/write, split into two bytes.
  - err_status: 2-bit, read-only, mirrored from a core input.
- Zero-wait-state OKAY responses; two-cycle ERROR response for illegal accesses.
- Sits between the AHB interconnect and the downstream datapath, which consumes payload and data_size.

Parameters:
- ERR_STATUS_ADDRESS, 1, byte address of the read-only err_status register.
- PAYLOAD_ADDRESS, 2, byte address of payload[7:0]; payload[15:8] is at PAYLOAD_ADDRESS+1.
- DATA_SIZE_ADDRESS, 4, byte address of data_size.

Ports:
- hclk  in  1  bus clock; all logic on its rising edge.
- hreset_n  in  1  reset, synchronous, active-low.
- hsel_x  in  1  slave select.
- hready  in  1  bus HREADY; previous transfer complete, address phase may be sampled.
- hwrite  in  1  1=write, 0=read.
- haddr  in  3  byte address.
- htrans  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- hsize  in  3  transfer size (0 byte, 1 halfword, ≥2 illegal).
- hwdata  in  8  write data, valid in the data phase.
- err_status  in  2  status from core, readable at ERR_STATUS_ADDRESS.
- payload  out  16  payload register.
- data_size  out  5  data_size register.
- hrdata  out  8  read data, valid in the data phase.
- hready_out  out  1  slave HREADYOUT.
- hresp  out  1  0 OKAY, 1 ERROR.

Behaviour:
- Reset (hreset_n=0 at a rising hclk edge) sets:
  - payload=0, data_size=0, hrdata=0, hready_out=1, hresp=0.
  - Pending data phase cleared; error FSM returns to IDLE.
  - Reset mid-transfer aborts the transfer; no register is written.
- Address-phase acceptance: on a rising edge where hsel_x=1, hready=1 and htrans[1]=1 (NONSEQ/SEQ), latch haddr, hwrite and hsize, and mark a data phase pending for the next cycle.
  - IDLE/BUSY, hsel_x=0 or hready=0 accept nothing; no data phase follows, and the response is OKAY with hready_out=1.
- Legality, decided at acceptance:
  - Illegal: hsize≥2; hsize=1 with haddr[0]=1 (misaligned); address not in {ERR_STATUS, PAYLOAD, PAYLOAD+1, DATA_SIZE}; any write to ERR_STATUS_ADDRESS.
- Legal write:
  - Completes in one data-phase cycle (hready_out=1, hresp=0).
  - At the end of that cycle, hwdata is written to the addressed register.
  - PAYLOAD → payload[7:0]; PAYLOAD+1 → payload[15:8]; DATA_SIZE → data_size ← hwdata[4:0], upper bits ignored.
  - A halfword write at PAYLOAD_ADDRESS updates payload[7:0] only (8-bit bus).
- Legal read:
  - Completes in one data-phase cycle.
  - hrdata is a combinational mux on the latched address, so a write completing in the preceding cycle is visible.
  - ERR_STATUS → {6'b0,err_status}; PAYLOAD/+1 → the byte; DATA_SIZE → {3'b0,data_size}.
  - hrdata=0 outside a read data phase.
- Illegal transfer, error FSM IDLE → ERR1 → ERR2 → IDLE:
  - ERR1: hready_out=0, hresp=1.
  - ERR2: hready_out=1, hresp=1.
  - No register changes.
  - A new address phase may be accepted at the end of ERR2 (hready=1).
- Back-to-back transfers: a data phase and the next address phase overlap in the same cycle; pipelining must be correct at full rate.
- payload and data_size outputs are driven directly from their registers.

Decomposition:
- Shared package ahb_pkg: htrans enum (IDLE, BUSY, NONSEQ, SEQ); hsize constants (BYTE=0, HALF=1); hresp constants (OKAY=0, ERROR=1).
- Single module; no sub-module needed. Optional small ahb_err_fsm if preferred.

Test Plan:
- Reset → payload=0, data_size=0, hrdata=0, hready_out=1, hresp=0.
- Write DATA_SIZE (addr 4, hsize 0, NONSEQ) with data phase hwdata=12 → data_size=12 one cycle after the data phase, OKAY zero-wait. Then write PAYLOAD (addr 2, hsize 1) with hwdata=8'h29 → payload=16'h0029.
- Write addr 3, hsize 0, hwdata=8'h0D → payload=16'h0D29. Pipelined read of addr 4 in the next cycle → hrdata=8'd12 in its data phase.
- Read addr 1 with err_status=2'b10 → hrdata=8'h02 OKAY. Write addr 1 → ERR1 (hready_out=0, hresp=1), ERR2 (1,1), err_status unchanged.
- Illegal accesses each → two-cycle ERROR, registers unchanged: addr 0; addr 3 with hsize 1; addr 4 with hsize 2.
- IDLE with hsel_x=1, and hready=0 with NONSEQ → no write, OKAY. Assert hreset_n=0 during a pending write data phase → write dropped, all outputs at reset values on the next edge.
